// File: rtl/sq_fwd.sv
// sq_fwd: store queue between dispatch/LSU and the D$ write port.
// Stores enter speculatively, are marked committed in order by the ROB and
// drain to memory from the head once committed. A flush rewinds the tail to
// the commit pointer, so committed stores survive. Loads probe the queue
// combinationally and get byte-granular forwarding from the youngest older
// store covering each byte.
//
// Handshakes: alloc lanes are taken only when alloc_ready_o is high, and then
// all valid lanes are taken together. A pop fires on pop_valid_i && pop_ready_o.
// Neither ready depends on the same-cycle valid.
module sq_fwd #(
   parameter int ROB_IDX_WIDTH = 6,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 16,
   parameter int ALLOC_PORTS   = 2,
   parameter int COMMIT_PORTS  = 2,
   localparam int BE_W  = DATA_WIDTH / 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int CC_W  = $clog2(COMMIT_PORTS + 1)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   flush_i,
   input  logic [ALLOC_PORTS-1:0]                 alloc_valid_i,
   output logic                                   alloc_ready_o,
   input  logic [ALLOC_PORTS*ROB_IDX_WIDTH-1:0]   alloc_rob_tag_i,
   input  logic [ALLOC_PORTS*ADDR_WIDTH-1:0]      alloc_addr_i,
   input  logic [ALLOC_PORTS*DATA_WIDTH-1:0]      alloc_data_i,
   input  logic [ALLOC_PORTS*BE_W-1:0]            alloc_be_i,
   output logic [PTR_W:0]                         alloc_tail_o,
   input  logic [CC_W-1:0]                        commit_cnt_i,
   input  logic                                   pop_valid_i,
   output logic                                   pop_ready_o,
   output logic                                   head_valid_o,
   output logic [ROB_IDX_WIDTH-1:0]               head_rob_tag_o,
   output logic [ADDR_WIDTH-1:0]                  head_addr_o,
   output logic [DATA_WIDTH-1:0]                  head_data_o,
   output logic [BE_W-1:0]                        head_be_o,
   input  logic                                   ld_valid_i,
   input  logic [ADDR_WIDTH-1:0]                  ld_addr_i,
   input  logic [BE_W-1:0]                        ld_be_i,
   input  logic [PTR_W:0]                         ld_sq_tail_i,
   output logic [BE_W-1:0]                        fwd_mask_o,
   output logic [DATA_WIDTH-1:0]                  fwd_data_o,
   output logic                                   fwd_full_o,
   output logic [CNT_W-1:0]                       count_o,
   output logic [CNT_W-1:0]                       commit_count_o,
   output logic                                   full_o,
   output logic                                   empty_o
);

   localparam int PW    = PTR_W + 1;
   localparam int OFF_W = $clog2(BE_W);

   // Entry storage; not reset, validity comes from the pointers alone.
   logic [ROB_IDX_WIDTH-1:0] tag_mem  [DEPTH];
   logic [ADDR_WIDTH-1:0]    addr_mem [DEPTH];
   logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
   logic [BE_W-1:0]          be_mem   [DEPTH];

   // Pointers carry a wrap bit: head <= commit <= tail in age order.
   logic [PW-1:0] head_ptr, cmt_ptr, tail_ptr;
   logic [PW-1:0] used, committed, uncommitted;
   logic [PW-1:0] n_alloc, commit_req, commit_amt;
   logic [PW-1:0] head_nxt, cmt_nxt, tail_nxt;
   logic [PW-1:0] ld_age;
   logic          accept, pop;
   logic [PTR_W-1:0] wr_idx [ALLOC_PORTS];
   logic [PTR_W-1:0] head_idx;

   assign used        = tail_ptr - head_ptr;
   assign committed   = cmt_ptr - head_ptr;
   assign uncommitted = tail_ptr - cmt_ptr;
   assign head_idx    = head_ptr[PTR_W-1:0];

   assign alloc_ready_o  = (int'(used) + ALLOC_PORTS) <= DEPTH;
   assign alloc_tail_o   = tail_ptr;
   assign count_o        = CNT_W'(used);
   assign commit_count_o = CNT_W'(committed);
   assign full_o         = (used == PW'(DEPTH));
   assign empty_o        = (used == '0);

   assign head_valid_o   = (committed != '0);
   assign pop_ready_o    = head_valid_o;
   assign head_rob_tag_o = head_valid_o ? tag_mem[head_idx]  : '0;
   assign head_addr_o    = head_valid_o ? addr_mem[head_idx] : '0;
   assign head_data_o    = head_valid_o ? data_mem[head_idx] : '0;
   assign head_be_o      = head_valid_o ? be_mem[head_idx]   : '0;

   // A flush cancels this cycle's allocs; the tail is rewound instead.
   assign accept = alloc_ready_o && !flush_i;
   assign pop    = pop_valid_i && head_valid_o;

   // Clamp an over-large commit count to the uncommitted entries present.
   assign commit_req = PW'(commit_cnt_i);
   assign commit_amt = (commit_req > uncommitted) ? uncommitted : commit_req;

   // Count accepted lanes and give each lane its slot behind the tail.
   always_comb begin
      n_alloc = '0;
      for (int i = 0; i < ALLOC_PORTS; i++) begin
         wr_idx[i] = tail_ptr[PTR_W-1:0] + PTR_W'(i);
         if (accept) n_alloc = n_alloc + PW'(alloc_valid_i[i]);
      end
   end

   // Next pointers: commit first, flush rewinds the tail to the new commit point, pop applies regardless.
   always_comb begin
      head_nxt = head_ptr + PW'(pop);
      cmt_nxt  = cmt_ptr + commit_amt;
      tail_nxt = flush_i ? cmt_nxt : (tail_ptr + n_alloc);
   end

   // Pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_ptr <= '0;
         cmt_ptr  <= '0;
         tail_ptr <= '0;
      end else begin
         head_ptr <= head_nxt;
         cmt_ptr  <= cmt_nxt;
         tail_ptr <= tail_nxt;
      end
   end

   // Write accepted lanes into their slots.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < ALLOC_PORTS; i++) begin
         if (!rst_i && accept && alloc_valid_i[i]) begin
            tag_mem[wr_idx[i]]  <= alloc_rob_tag_i[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
            addr_mem[wr_idx[i]] <= alloc_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_mem[wr_idx[i]] <= alloc_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            be_mem[wr_idx[i]]   <= alloc_be_i[i*BE_W +: BE_W];
         end
      end
   end

   assign ld_age = ld_sq_tail_i - head_ptr;

   // Forwarding: walk entries oldest to youngest so younger matches overwrite older bytes.
   always_comb begin
      logic [PTR_W-1:0] fidx;
      fidx       = '0;
      fwd_mask_o = '0;
      fwd_data_o = '0;
      for (int a = 0; a < DEPTH; a++) begin
         fidx = head_idx + PTR_W'(a);
         if (ld_valid_i && (PW'(a) < used) && (PW'(a) < ld_age) &&
             (addr_mem[fidx][ADDR_WIDTH-1:OFF_W] == ld_addr_i[ADDR_WIDTH-1:OFF_W])) begin
            for (int b = 0; b < BE_W; b++) begin
               if (be_mem[fidx][b]) begin
                  fwd_mask_o[b]        = 1'b1;
                  fwd_data_o[b*8 +: 8] = data_mem[fidx][b*8 +: 8];
               end
            end
         end
      end
   end

   assign fwd_full_o = ld_valid_i && (ld_be_i != '0) && ((ld_be_i & ~fwd_mask_o) == '0);

   // Protocol checks on the upstream interfaces.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (commit_req <= uncommitted)
            else $error("sq_fwd: commit_cnt_i exceeds uncommitted entries");
         assert ((alloc_valid_i & (alloc_valid_i + ALLOC_PORTS'(1))) == '0)
            else $error("sq_fwd: alloc_valid_i lanes not contiguous from lane 0");
      end
   end

endmodule

// File: tb/tb_sq_fwd.sv
// tb_sq_fwd: directed plus randomized checks of sq_fwd (DEPTH=8, 2 alloc
// lanes, 2 commit lanes, 32-bit data) against a queue-of-stores model.
module tb_sq_fwd;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  alloc_valid;
   logic        alloc_ready;
   logic [11:0] alloc_rob_tag;
   logic [63:0] alloc_addr;
   logic [63:0] alloc_data;
   logic [7:0]  alloc_be;
   logic [3:0]  alloc_tail;
   logic [1:0]  commit_cnt;
   logic        pop_valid;
   logic        pop_ready;
   logic        head_valid;
   logic [5:0]  head_rob_tag;
   logic [31:0] head_addr;
   logic [31:0] head_data;
   logic [3:0]  head_be;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [3:0]  ld_be;
   logic [3:0]  ld_sq_tail;
   logic [3:0]  fwd_mask;
   logic [31:0] fwd_data;
   logic        fwd_full;
   logic [3:0]  count;
   logic [3:0]  commit_count;
   logic        full;
   logic        empty;

   sq_fwd #(
      .ROB_IDX_WIDTH(6), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .DEPTH(DEPTH), .ALLOC_PORTS(2), .COMMIT_PORTS(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
      .alloc_rob_tag_i(alloc_rob_tag), .alloc_addr_i(alloc_addr),
      .alloc_data_i(alloc_data), .alloc_be_i(alloc_be),
      .alloc_tail_o(alloc_tail), .commit_cnt_i(commit_cnt),
      .pop_valid_i(pop_valid), .pop_ready_o(pop_ready),
      .head_valid_o(head_valid), .head_rob_tag_o(head_rob_tag),
      .head_addr_o(head_addr), .head_data_o(head_data), .head_be_o(head_be),
      .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_be_i(ld_be),
      .ld_sq_tail_i(ld_sq_tail), .fwd_mask_o(fwd_mask), .fwd_data_o(fwd_data),
      .fwd_full_o(fwd_full), .count_o(count), .commit_count_o(commit_count),
      .full_o(full), .empty_o(empty)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   // Reference model: stores in age order, oldest first; the first m_nc are committed.
   typedef struct {
      int          seq;
      logic [5:0]  tag;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ent_t;

   ent_t mq[$];
   int   m_nc     = 0;
   int   m_head   = 0;
   int   next_seq = 0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0]  l_tag  [2];
   logic [31:0] l_addr [2];
   logic [31:0] l_data [2];
   logic [3:0]  l_be   [2];

   function automatic int m_tail();
      return (m_head + mq.size()) % (2 * DEPTH);
   endfunction

   function automatic int min2(input int x);
      return (x < 2) ? x : 2;
   endfunction

   task automatic check(input string where, input string what,
                        input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s observed=0x%0h expected=0x%0h", where, what, obs, exp);
      end
   endtask

   task automatic check_state(input string where);
      int sz;
      sz = mq.size();
      check(where, "count",        64'(count),        64'(sz));
      check(where, "commit_count", 64'(commit_count), 64'(m_nc));
      check(where, "full",         64'(full),         64'(sz == DEPTH));
      check(where, "empty",        64'(empty),        64'(sz == 0));
      check(where, "alloc_ready",  64'(alloc_ready),  64'(sz + 2 <= DEPTH));
      check(where, "head_valid",   64'(head_valid),   64'(m_nc > 0));
      check(where, "pop_ready",    64'(pop_ready),    64'(m_nc > 0));
      check(where, "alloc_tail",   64'(alloc_tail),   64'(m_tail()));
      check(where, "head_tag",  64'(head_rob_tag), (m_nc > 0) ? 64'(mq[0].tag)  : 64'(0));
      check(where, "head_addr", 64'(head_addr),    (m_nc > 0) ? 64'(mq[0].addr) : 64'(0));
      check(where, "head_data", 64'(head_data),    (m_nc > 0) ? 64'(mq[0].data) : 64'(0));
      check(where, "head_be",   64'(head_be),      (m_nc > 0) ? 64'(mq[0].be)   : 64'(0));
      check(where, "idle_fwd",  {fwd_full, fwd_mask, fwd_data}, 64'(0));
   endtask

   task automatic rand_lanes();
      for (int i = 0; i < 2; i++) begin
         l_tag[i]  = 6'($urandom);
         l_addr[i] = 32'h100 + 32'($urandom_range(0, 7));
         l_data[i] = $urandom;
         l_be[i]   = 4'($urandom_range(1, 15));
      end
   endtask

   // Driver: one clock with the given lanes/commit/pop/flush, then update model and check.
   task automatic step(input string where, input int nl, input int cm,
                       input bit pv, input bit fl);
      bit m_ready, m_pop;
      alloc_valid   = (nl >= 2) ? 2'b11 : (nl == 1) ? 2'b01 : 2'b00;
      alloc_rob_tag = {l_tag[1], l_tag[0]};
      alloc_addr    = {l_addr[1], l_addr[0]};
      alloc_data    = {l_data[1], l_data[0]};
      alloc_be      = {l_be[1], l_be[0]};
      commit_cnt    = 2'(cm);
      pop_valid     = pv;
      flush         = fl;
      m_ready = (mq.size() + 2 <= DEPTH);
      m_pop   = pv && (m_nc > 0);
      @(posedge clk);
      #1;
      alloc_valid = 2'b00;
      commit_cnt  = 2'd0;
      pop_valid   = 1'b0;
      flush       = 1'b0;
      m_nc = m_nc + cm;
      if (fl) begin
         while (mq.size() > m_nc) void'(mq.pop_back());
      end else if (m_ready) begin
         for (int i = 0; i < nl; i++) begin
            ent_t e;
            e.seq = next_seq; e.tag = l_tag[i]; e.addr = l_addr[i];
            e.data = l_data[i]; e.be = l_be[i];
            next_seq++;
            mq.push_back(e);
         end
      end
      if (m_pop) begin
         void'(mq.pop_front());
         m_nc--;
         m_head = (m_head + 1) % (2 * DEPTH);
      end
      check_state(where);
   endtask

   // Load probe; snapshot given as model sequence number plus the matching tail pointer.
   task automatic probe(input string where, input logic [31:0] a, input logic [3:0] be,
                        input int snap_seq, input int snap_ptr);
      logic [3:0]  e_mask;
      logic [31:0] e_data;
      ld_valid   = 1'b1;
      ld_addr    = a;
      ld_be      = be;
      ld_sq_tail = 4'(snap_ptr);
      #1;
      e_mask = '0;
      e_data = '0;
      foreach (mq[j]) begin
         if (mq[j].seq < snap_seq && mq[j].addr[31:2] == a[31:2]) begin
            for (int b = 0; b < 4; b++) begin
               if (mq[j].be[b]) begin
                  e_mask[b]        = 1'b1;
                  e_data[b*8 +: 8] = mq[j].data[b*8 +: 8];
               end
            end
         end
      end
      check(where, "fwd_mask", 64'(fwd_mask), 64'(e_mask));
      check(where, "fwd_data", 64'(fwd_data), 64'(e_data));
      check(where, "fwd_full", 64'(fwd_full), 64'((be != 4'd0) && ((be & ~e_mask) == 4'd0)));
      ld_valid = 1'b0;
      ld_addr  = '0;
      ld_be    = '0;
   endtask

   task automatic drain(input string where);
      for (int k = 0; k < 40 && mq.size() > 0; k++)
         step(where, 0, min2(mq.size() - m_nc), 1'b1, 1'b0);
   endtask

   task automatic model_reset();
      mq.delete();
      m_nc   = 0;
      m_head = 0;
   endtask

   initial begin
      int snap_a_seq, snap_a_ptr, snap_b_seq, snap_b_ptr, snap_c_seq, snap_c_ptr;
      int j, cm, sseq;
      rst = 1'b1; flush = 1'b0; alloc_valid = '0; alloc_rob_tag = '0;
      alloc_addr = '0; alloc_data = '0; alloc_be = '0; commit_cnt = '0;
      pop_valid = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_be = '0; ld_sq_tail = '0;
      for (int i = 0; i < 2; i++) begin
         l_tag[i] = '0; l_addr[i] = '0; l_data[i] = '0; l_be[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_state("reset");

      // 1: fill to full, extra alloc ignored, commit 2
      for (int k = 0; k < 4; k++) begin
         rand_lanes();
         step("t1_fill", 2, 0, 1'b0, 1'b0);
      end
      rand_lanes();
      step("t1_over", 2, 0, 1'b0, 1'b0);
      step("t1_commit", 0, 2, 1'b0, 1'b0);

      // 2: pops interleaved with 2-lane allocs across the wrap
      for (int k = 0; k < 8; k++) begin
         rand_lanes();
         step("t2_wrap", 2, min2(mq.size() - m_nc), 1'b1, 1'b0);
      end
      drain("t2_drain");

      // 3: 4 allocs, commit 1, flush, then a new alloc lands right behind the survivor
      rand_lanes(); step("t3_alloc", 2, 0, 1'b0, 1'b0);
      rand_lanes(); step("t3_alloc", 2, 0, 1'b0, 1'b0);
      step("t3_commit", 0, 1, 1'b0, 1'b0);
      step("t3_flush", 0, 0, 1'b0, 1'b1);
      check("t3", "tail_after_flush", 64'(alloc_tail), 64'((m_head + 1) % 16));
      l_tag[0] = 6'h2A; l_addr[0] = 32'h200; l_data[0] = 32'hCAFEF00D; l_be[0] = 4'hF;
      step("t3_realloc", 1, 0, 1'b0, 1'b0);
      step("t3_popold", 0, 1, 1'b1, 1'b0);
      check("t3", "new_head_data", 64'(head_data), 64'(32'hCAFEF00D));
      drain("t3_drain");

      // 4/5: two overlapping stores, probes with different snapshots
      snap_a_seq = next_seq; snap_a_ptr = m_tail();
      l_tag[0] = 6'h01; l_addr[0] = 32'h100; l_data[0] = 32'h11223344; l_be[0] = 4'hF;
      step("t4_st_a", 1, 0, 1'b0, 1'b0);
      snap_b_seq = next_seq; snap_b_ptr = m_tail();
      l_tag[0] = 6'h02; l_addr[0] = 32'h100; l_data[0] = 32'h0000AABB; l_be[0] = 4'h3;
      step("t4_st_b", 1, 0, 1'b0, 1'b0);
      snap_c_seq = next_seq; snap_c_ptr = m_tail();
      probe("t4_after", 32'h100, 4'hF, snap_c_seq, snap_c_ptr);
      ld_valid = 1'b1; ld_addr = 32'h100; ld_be = 4'hF; ld_sq_tail = 4'(snap_c_ptr);
      #1;
      check("t4", "data_lit", 64'(fwd_data), 64'(32'h1122AABB));
      check("t4", "full_lit", 64'(fwd_full), 64'(1));
      ld_valid = 1'b0;
      probe("t5_between", 32'h100, 4'hF, snap_b_seq, snap_b_ptr);
      probe("t5_before", 32'h100, 4'hF, snap_a_seq, snap_a_ptr);
      probe("t5_otherword", 32'h104, 4'hF, snap_c_seq, snap_c_ptr);
      probe("t5_lowhalf", 32'h102, 4'h3, snap_c_seq, snap_c_ptr);
      step("t5_commit", 0, 1, 1'b0, 1'b0);
      probe("t5_mixed", 32'h100, 4'hF, snap_c_seq, snap_c_ptr);
      drain("t5_drain");

      // 6: full queue with pop + allocs, then pop + commit + flush together
      for (int k = 0; k < 4; k++) begin
         rand_lanes();
         step("t6_fill", 2, 0, 1'b0, 1'b0);
      end
      step("t6_commit", 0, 2, 1'b0, 1'b0);
      rand_lanes();
      step("t6_pop_alloc", 2, 0, 1'b1, 1'b0);
      step("t6_pop_cmt_flush", 0, 2, 1'b1, 1'b1);

      // randomized traffic with random probes
      for (int k = 0; k < 300; k++) begin
         rand_lanes();
         cm = int'($urandom_range(0, min2(mq.size() - m_nc)));
         step("rnd", int'($urandom_range(0, 2)), cm, 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0);
         j = int'($urandom_range(0, mq.size()));
         sseq = (j < mq.size()) ? mq[j].seq : next_seq;
         probe("rnd_probe", 32'h100 + 32'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               sseq, (m_head + j) % 16);
      end

      // reset in the middle of traffic
      rand_lanes();
      alloc_valid = 2'b11;
      alloc_addr  = {l_addr[1], l_addr[0]};
      pop_valid   = 1'b1;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; alloc_valid = '0; pop_valid = 1'b0;
      model_reset();
      check_state("mid_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
